// File: rtl/invmap_pkg.sv
// Shared types and constants for the inverse false-colour map (invmap).
// Optional early-exit search is selected with INVMAP_EARLY_EXIT_EN (see invmap.sv).
package invmap_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SEARCH = 2'd1,
      ST_DONE   = 2'd2
   } state_t;

   // Cycles from an address leaving the counter to its compare/update: read, distance, compare.
   localparam int PIPE_DEPTH = 3;

   function automatic int dist_width(input int cw);
      return cw + 2;
   endfunction

endpackage

// File: rtl/invmap_if.sv
// Bus interface of invmap: palette write port, query handshake and result handshake.
interface invmap_if #(
   parameter int LGN = 8,
   parameter int CW  = 8
);
   logic              i_wr;
   logic [LGN-1:0]    i_waddr;
   logic [3*CW-1:0]   i_wdata;
   logic              i_valid;
   logic              o_ready;
   logic [CW-1:0]     i_r;
   logic [CW-1:0]     i_g;
   logic [CW-1:0]     i_b;
   logic              o_valid;
   logic              i_ready;
   logic [LGN-1:0]    o_index;
   logic [CW+1:0]     o_dist;
   logic              o_busy;

   modport slave (
      input  i_wr, i_waddr, i_wdata, i_valid, i_r, i_g, i_b, i_ready,
      output o_ready, o_valid, o_index, o_dist, o_busy
   );

   modport master (
      output i_wr, i_waddr, i_wdata, i_valid, i_r, i_g, i_b, i_ready,
      input  o_ready, o_valid, o_index, o_dist, o_busy
   );
endinterface

// File: rtl/invmap_dist.sv
// Registered L1 colour distance |dr|+|dg|+|db| between two packed {r,g,b} pixels.
module invmap_dist #(
   parameter int CW = 8,
   parameter int DW = CW + 2
) (
   input  logic            i_clk,
   input  logic            i_reset,
   input  logic [3*CW-1:0] i_a,
   input  logic [3*CW-1:0] i_b,
   output logic [DW-1:0]   o_dist
);

   function automatic logic [CW-1:0] absdiff(input logic [CW-1:0] x, input logic [CW-1:0] y);
      if (x >= y) begin
         return x - y;
      end else begin
         return y - x;
      end
   endfunction

   logic [CW-1:0] dr_s, dg_s, db_s;
   logic [DW-1:0] sum_s;

   // Per-channel differences widened before summing so three full-scale terms cannot overflow.
   always_comb begin
      dr_s  = absdiff(i_a[3*CW-1:2*CW], i_b[3*CW-1:2*CW]);
      dg_s  = absdiff(i_a[2*CW-1:CW],   i_b[2*CW-1:CW]);
      db_s  = absdiff(i_a[CW-1:0],      i_b[CW-1:0]);
      sum_s = {{(DW-CW){1'b0}}, dr_s} + {{(DW-CW){1'b0}}, dg_s} + {{(DW-CW){1'b0}}, db_s};
   end

   // Distance output register.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         o_dist <= {DW{1'b0}};
      end else begin
         o_dist <= sum_s;
      end
   end

endmodule

// File: rtl/invmap.sv
// Inverse false-colour map: sequential nearest-palette-entry search per query pixel.
// Define INVMAP_EARLY_EXIT_EN to end the sweep at the first exact (distance 0) match.
module invmap
   import invmap_pkg::*;
#(
   parameter int LGN = 8,
   parameter int CW  = 8
) (
   input  logic     i_clk,
   input  logic     i_reset,
   invmap_if.slave  bus
);

   localparam int NENT = 2 ** LGN;
   localparam int DW   = dist_width(CW);

   logic [3*CW-1:0] mem_r [NENT];
   logic [3*CW-1:0] rdata_r;
   logic [3*CW-1:0] query_r;

   state_t          state_r, state_s;
   logic            accept_s, wr_en_s;

   logic [LGN-1:0]  addr_r;
   logic            sweep_done_r;
   logic            t1_v_r, t2_v_r;
   logic [LGN-1:0]  t1_idx_r, t2_idx_r;

   logic [DW-1:0]   dist_s;
   logic [DW-1:0]   best_dist_r;
   logic [LGN-1:0]  best_idx_r;
   logic            take_s, end_s, cmp_end_r;

   logic            valid_s, ready_s, busy_s;
   logic            valid_r, ready_r, busy_r;
   logic [LGN-1:0]  index_r;
   logic [DW-1:0]   dist_out_r;

   assign accept_s = (state_r == ST_IDLE) && bus.i_valid;
   assign wr_en_s  = bus.i_wr && (state_r != ST_SEARCH);

   // Palette write port; contents survive reset.
   always_ff @(posedge i_clk) begin
      if (wr_en_s) begin
         mem_r[bus.i_waddr] <= bus.i_wdata;
      end
   end

   // Palette registered read port.
   always_ff @(posedge i_clk) begin
      rdata_r <= mem_r[addr_r];
   end

   // Query latch, address sweep and index/valid tags travelling alongside the read and distance stages.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         query_r      <= {(3*CW){1'b0}};
         addr_r       <= {LGN{1'b0}};
         sweep_done_r <= 1'b1;
         t1_v_r       <= 1'b0;
         t1_idx_r     <= {LGN{1'b0}};
         t2_v_r       <= 1'b0;
         t2_idx_r     <= {LGN{1'b0}};
      end else if (accept_s) begin
         query_r      <= {bus.i_r, bus.i_g, bus.i_b};
         addr_r       <= {LGN{1'b0}};
         sweep_done_r <= 1'b0;
         t1_v_r       <= 1'b0;
         t2_v_r       <= 1'b0;
      end else if (state_r == ST_SEARCH) begin
         t1_v_r   <= !sweep_done_r;
         t1_idx_r <= addr_r;
         t2_v_r   <= t1_v_r;
         t2_idx_r <= t1_idx_r;
         if (!sweep_done_r) begin
            addr_r <= addr_r + {{(LGN-1){1'b0}}, 1'b1};
            if (addr_r == {LGN{1'b1}}) begin
               sweep_done_r <= 1'b1;
            end
         end
      end else begin
         // Leaving SEARCH (early exit or done) drops anything still in flight.
         sweep_done_r <= 1'b1;
         t1_v_r       <= 1'b0;
         t2_v_r       <= 1'b0;
      end
   end

   invmap_dist #(.CW(CW), .DW(DW)) u_dist (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .i_a     (rdata_r),
      .i_b     (query_r),
      .o_dist  (dist_s)
   );

   // Entry 0 seeds the best match; strict less-than keeps the lowest index on ties.
   always_comb begin
      take_s = (t2_idx_r == {LGN{1'b0}}) || (dist_s < best_dist_r);
`ifdef INVMAP_EARLY_EXIT_EN
      end_s  = (t2_idx_r == {LGN{1'b1}}) || (dist_s == {DW{1'b0}});
`else
      end_s  = (t2_idx_r == {LGN{1'b1}});
`endif
   end

   // Compare/update stage.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         best_dist_r <= {DW{1'b0}};
         best_idx_r  <= {LGN{1'b0}};
         cmp_end_r   <= 1'b0;
      end else if (accept_s) begin
         cmp_end_r <= 1'b0;
      end else if ((state_r == ST_SEARCH) && t2_v_r && !cmp_end_r) begin
         if (take_s) begin
            best_dist_r <= dist_s;
            best_idx_r  <= t2_idx_r;
         end
         if (end_s) begin
            cmp_end_r <= 1'b1;
         end
      end
   end

   // FSM next state.
   always_comb begin
      state_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (accept_s) begin
               state_s = ST_SEARCH;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_SEARCH: begin
            if (cmp_end_r) begin
               state_s = ST_DONE;
            end else begin
               state_s = ST_SEARCH;
            end
         end
         ST_DONE: begin
            if (bus.i_ready) begin
               state_s = ST_IDLE;
            end else begin
               state_s = ST_DONE;
            end
         end
         default: state_s = ST_IDLE;
      endcase
   end

   // Output decode from the next state, so the registered outputs line up with the state.
   always_comb begin
      valid_s = (state_s == ST_DONE);
      ready_s = (state_s == ST_IDLE);
      busy_s  = (state_s == ST_SEARCH);
   end

   // State register and registered outputs; the result is captured once on entry to DONE.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state_r    <= ST_IDLE;
         valid_r    <= 1'b0;
         ready_r    <= 1'b1;
         busy_r     <= 1'b0;
         index_r    <= {LGN{1'b0}};
         dist_out_r <= {DW{1'b0}};
      end else begin
         state_r <= state_s;
         valid_r <= valid_s;
         ready_r <= ready_s;
         busy_r  <= busy_s;
         if ((state_r == ST_SEARCH) && (state_s == ST_DONE)) begin
            index_r    <= best_idx_r;
            dist_out_r <= best_dist_r;
         end
      end
   end

   assign bus.o_valid = valid_r;
   assign bus.o_ready = ready_r;
   assign bus.o_busy  = busy_r;
   assign bus.o_index = index_r;
   assign bus.o_dist  = dist_out_r;

endmodule

// File: tb/tb_invmap.sv
// Directed self-checking bench for invmap (default 256-entry, 8-bit palette).
module tb_invmap;
   import invmap_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   failures = 0;
   int   cnt;
   logic seen;
   logic [7:0]  hold_idx;
   logic [9:0]  hold_dist;

   invmap_if #(.LGN(8), .CW(8)) bus ();

   invmap #(.LGN(8), .CW(8)) dut (
      .i_clk   (clk),
      .i_reset (rst),
      .bus     (bus)
   );

   always #5 clk = ~clk;

`ifdef INVMAP_EARLY_EXIT_EN
   localparam int LAT_T1 = 68;
`else
   localparam int LAT_T1 = 256 + PIPE_DEPTH;
`endif

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic query(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
      bus.i_valid = 1'b1;
      bus.i_r = r;
      bus.i_g = g;
      bus.i_b = b;
      step();
      bus.i_valid = 1'b0;
   endtask

   task automatic wait_valid(output int n);
      n = 0;
      while (!bus.o_valid && n < 1000) begin
         step();
         n++;
      end
      check("valid_seen", {31'd0, bus.o_valid}, 32'd1);
   endtask

   task automatic release_result(input string tag);
      bus.i_ready = 1'b1;
      step();
      bus.i_ready = 1'b0;
      check({tag, "_valid_drop"}, {31'd0, bus.o_valid}, 32'd0);
      check({tag, "_ready_back"}, {31'd0, bus.o_ready}, 32'd1);
   endtask

   initial begin
      bus.i_wr = 1'b0;
      bus.i_waddr = 8'd0;
      bus.i_wdata = 24'd0;
      bus.i_valid = 1'b0;
      bus.i_r = 8'd0;
      bus.i_g = 8'd0;
      bus.i_b = 8'd0;
      bus.i_ready = 1'b0;

      // Reset state
      repeat (3) step();
      check("rst_valid", {31'd0, bus.o_valid}, 32'd0);
      check("rst_ready", {31'd0, bus.o_ready}, 32'd1);
      check("rst_busy",  {31'd0, bus.o_busy},  32'd0);
      check("rst_index", {24'd0, bus.o_index}, 32'd0);
      check("rst_dist",  {22'd0, bus.o_dist},  32'd0);
      rst = 1'b0;
      step();

      // Grey ramp palette: entry i = {i,i,i}
      bus.i_wr = 1'b1;
      for (int i = 0; i < 256; i++) begin
         bus.i_waddr = 8'(i);
         bus.i_wdata = {8'(i), 8'(i), 8'(i)};
         step();
      end
      bus.i_wr = 1'b0;

      // T1: exact match and latency
      query(8'h40, 8'h40, 8'h40);
      check("t1_ready_low", {31'd0, bus.o_ready}, 32'd0);
      check("t1_busy",      {31'd0, bus.o_busy},  32'd1);
      wait_valid(cnt);
      check("t1_latency", 32'(cnt), 32'(LAT_T1));
      check("t1_index", {24'd0, bus.o_index}, 32'h40);
      check("t1_dist",  {22'd0, bus.o_dist},  32'd0);
      check("t1_busy_done", {31'd0, bus.o_busy}, 32'd0);
      release_result("t1");

      // T2: (41,40,3f) -> entry 0x40 at 1+0+1=2; entries 0x3f/0x41 are at 3
      query(8'h41, 8'h40, 8'h3f);
      wait_valid(cnt);
      check("t2_index", {24'd0, bus.o_index}, 32'h40);
      check("t2_dist",  {22'd0, bus.o_dist},  32'd2);
      release_result("t2");

      // Palette all zero except entry 200 = white
      bus.i_wr = 1'b1;
      for (int i = 0; i < 256; i++) begin
         bus.i_waddr = 8'(i);
         bus.i_wdata = (i == 200) ? 24'hffffff : 24'h000000;
         step();
      end
      bus.i_wr = 1'b0;

      // T3 + T4: far-index match, then held result under backpressure
      query(8'hf0, 8'hf0, 8'hf0);
      wait_valid(cnt);
      check("t3_index", {24'd0, bus.o_index}, 32'd200);
      check("t3_dist",  {22'd0, bus.o_dist},  32'd45);
      hold_idx = bus.o_index;
      hold_dist = bus.o_dist;
      for (int i = 0; i < 50; i++) begin
         step();
         check("t4_hold_valid", {31'd0, bus.o_valid}, 32'd1);
         check("t4_hold_ready", {31'd0, bus.o_ready}, 32'd0);
         check("t4_hold_index", {24'd0, bus.o_index}, {24'd0, hold_idx});
         check("t4_hold_dist",  {22'd0, bus.o_dist},  {22'd0, hold_dist});
      end
      release_result("t4");

      // Ties: black query matches 255 zero entries at distance 0 -> lowest index
      query(8'h00, 8'h00, 8'h00);
      wait_valid(cnt);
      check("tie_index", {24'd0, bus.o_index}, 32'd0);
      check("tie_dist",  {22'd0, bus.o_dist},  32'd0);
      release_result("tie");

      // T5: write during search is dropped
      query(8'h05, 8'h05, 8'h05);
      repeat (10) step();
      check("t5_busy", {31'd0, bus.o_busy}, 32'd1);
      bus.i_wr = 1'b1;
      bus.i_waddr = 8'd5;
      bus.i_wdata = 24'h050505;
      step();
      bus.i_wr = 1'b0;
      wait_valid(cnt);
      check("t5_index", {24'd0, bus.o_index}, 32'd0);
      check("t5_dist",  {22'd0, bus.o_dist},  32'd15);
      release_result("t5");
      query(8'h05, 8'h05, 8'h05);
      wait_valid(cnt);
      check("t5_requery_index", {24'd0, bus.o_index}, 32'd0);
      check("t5_requery_dist",  {22'd0, bus.o_dist},  32'd15);
      release_result("t5r");

      // Same-cycle write and acceptance: the search sees the new entry
      bus.i_wr = 1'b1;
      bus.i_waddr = 8'd5;
      bus.i_wdata = 24'h050505;
      query(8'h05, 8'h05, 8'h05);
      bus.i_wr = 1'b0;
      wait_valid(cnt);
      check("wa_index", {24'd0, bus.o_index}, 32'd5);
      check("wa_dist",  {22'd0, bus.o_dist},  32'd0);
      release_result("wa");

      // T6: reset mid-search aborts the query
      query(8'hf0, 8'hf0, 8'hf0);
      repeat (99) step();
      check("t6_busy_pre", {31'd0, bus.o_busy}, 32'd1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("t6_valid", {31'd0, bus.o_valid}, 32'd0);
      check("t6_ready", {31'd0, bus.o_ready}, 32'd1);
      check("t6_busy",  {31'd0, bus.o_busy},  32'd0);
      check("t6_index", {24'd0, bus.o_index}, 32'd0);
      seen = 1'b0;
      for (int i = 0; i < 300; i++) begin
         step();
         if (bus.o_valid) seen = 1'b1;
      end
      check("t6_no_valid", {31'd0, seen}, 32'd0);
      query(8'hf0, 8'hf0, 8'hf0);
      wait_valid(cnt);
      check("t6_latency", 32'(cnt), 32'(256 + PIPE_DEPTH));
      check("t6_index", {24'd0, bus.o_index}, 32'd200);
      check("t6_dist",  {22'd0, bus.o_dist},  32'd45);
      release_result("t6");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
